// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
// Bundles the fetch stage's bus signals: the decode-side redirect/stall inputs,
// the instruction SRAM read port, and the {pc, inst, valid, adel} bundle that
// is presented to decode.
//   master : the fetch stage (drives SRAM request and decode-facing outputs)
//   slave  : the surrounding pipeline/SRAM (drives stall, redirect, rdata)
// ----------------------------------------------------------------------------
interface if_stage_if;
   logic        stall;
   logic [1:0]  pcsource;
   logic [31:0] bpc;
   logic [31:0] jrpc;
   logic [31:0] jpc;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_valid;
   logic        o_adel;

   modport master (
      input  stall, pcsource, bpc, jrpc, jpc, inst_sram_rdata,
      output inst_sram_en, inst_sram_addr, o_pc, o_inst, o_valid, o_adel
   );

   modport slave (
      output stall, pcsource, bpc, jrpc, jpc, inst_sram_rdata,
      input  inst_sram_en, inst_sram_addr, o_pc, o_inst, o_valid, o_adel
   );
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of a five-stage MIPS pipeline. Owns the PC, picks
// the next PC from decode's redirect (pcsource/bpc/jrpc/jpc), drives a
// one-cycle-latency instruction SRAM and presents {pc, inst, valid, adel} to
// decode. A hold buffer freezes the fetched word while decode stalls.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : if_stage_if.master (stall, redirect, SRAM port, decode outputs)
// ----------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        reset,
   if_stage_if.master  bus
);

   logic [31:0] pc_reg;
   logic        valid;
   logic [31:0] hold_inst;
   logic        hold_valid;
   logic        fetched;

   logic [31:0] npc;
   logic        stalled;
   logic        adel;

   assign stalled = valid && bus.stall;

   // Redirect inputs only matter once a real instruction sits in decode and
   // decode is advancing; otherwise keep (re)addressing pc_reg.
   always_comb begin
      npc = pc_reg;
      if (valid && !bus.stall) begin
         case (bus.pcsource)
            2'b00:   npc = pc_reg + 32'd4;
            2'b01:   npc = bus.bpc;
            2'b10:   npc = bus.jrpc;
            default: npc = bus.jpc;
         endcase
      end
   end

   // Misaligned targets are never read; stalled cycles never re-read so the
   // SRAM output keeps the word that is being captured into the hold buffer.
   assign bus.inst_sram_addr = npc;
   assign bus.inst_sram_en   = (npc[1:0] == 2'b00) && !stalled;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg     <= RESET_PC;
         valid      <= 1'b0;
         hold_inst  <= 32'h0;
         hold_valid <= 1'b0;
         fetched    <= 1'b0;
      end else if (!valid) begin
         // Bootstrap edge: the read of pc_reg issued now lands next cycle.
         valid   <= 1'b1;
         fetched <= bus.inst_sram_en;
      end else if (!bus.stall) begin
         pc_reg     <= npc;
         hold_valid <= 1'b0;
         fetched    <= bus.inst_sram_en;
      end else if (!hold_valid) begin
         // First stalled edge: the SRAM still shows the word for pc_reg.
         hold_inst  <= bus.inst_sram_rdata;
         hold_valid <= 1'b1;
      end
   end

   assign adel = valid && (pc_reg[1:0] != 2'b00);

   always_comb begin
      bus.o_inst = 32'h0;
      if (adel)
         bus.o_inst = 32'h0;          // SLL $0 (NOP) for the exception path
      else if (hold_valid)
         bus.o_inst = hold_inst;
      else if (fetched)
         bus.o_inst = bus.inst_sram_rdata;
   end

   assign bus.o_pc    = pc_reg;
   assign bus.o_valid = valid;
   assign bus.o_adel  = adel;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the PC register and selects the next PC from the redirect information decode produces (`pcsource`, `bpc`, `jpc`, `jrpc`). It drives a synchronous instruction SRAM with one-cycle read latency and presents `{pc, inst, valid}` to decode. A hold buffer keeps the fetched instruction stable while decode stalls.

## Interface
- `RESET_PC`, default 32'hBFC0_0000, first fetch address after reset.
- `clk` in 1, rising-edge clock.
- `reset` in 1, asynchronous, active-low; 0 forces the reset state immediately.
- `stall` in 1, decode hazard stall; 1 holds PC and decode-facing outputs.
- `pcsource` in 2, next-PC select from decode: 00 PC+4, 01 `bpc`, 10 `jrpc`, 11 `jpc`.
- `bpc` in 32, branch target.
- `jrpc` in 32, register-jump target (forwarded rs).
- `jpc` in 32, J/JAL target.
- `inst_sram_en` out 1, SRAM read enable.
- `inst_sram_addr` out 32, SRAM read address (byte address).
- `inst_sram_rdata` in 32, SRAM data, valid one cycle after an enabled read.
- `o_pc` out 32, PC of the instruction presented to decode.
- `o_inst` out 32, instruction presented to decode.
- `o_valid` out 1, `o_pc`/`o_inst` are meaningful.
- `o_adel` out 1, `o_pc[1:0]` != 0 (fetch address error); `o_inst` forced to 0 when set.

## Operation
- State:
  - `pc_reg` (32).
  - `valid` (1).
  - `hold_inst` (32).
  - `hold_valid` (1).
  - `fetched` (1): the last edge issued an enabled read for `pc_reg`.
- Reset values:
  - `pc_reg` = RESET_PC; `valid` = 0; `hold_valid` = 0; `hold_inst` = 0; `fetched` = 0.
  - Outputs during reset: `o_pc` = RESET_PC, `o_valid` = 0, `o_adel` = 0.
- Next PC (`npc`), combinational:
  - `valid`=0: `npc` = `pc_reg` (bootstrap fetch).
  - `valid`=1, `stall`=1: `npc` = `pc_reg`.
  - Otherwise, by `pcsource`: `pc_reg`+4 (mod 2^32), `bpc`, `jrpc`, `jpc`.
- SRAM drive:
  - `inst_sram_addr` = `npc`.
  - `inst_sram_en` = 1 iff `npc[1:0]`==0 and not (`valid` && `stall`).
- Clock edge:
  - `valid`=0: `valid` <= 1; `pc_reg` unchanged.
  - `valid`=1, `stall`=0: `pc_reg` <= `npc`; `hold_valid` <= 0.
  - `valid`=1, `stall`=1, `hold_valid`=0: `hold_inst` <= `inst_sram_rdata`; `hold_valid` <= 1.
  - `valid`=1, `stall`=1, `hold_valid`=1: no change.
- Decode-facing outputs:
  - `o_pc` = `pc_reg`; `o_valid` = `valid`.
  - `o_adel` = `valid` && `pc_reg[1:0]`!=0.
  - `o_inst`:
    - `o_adel`=1: 0.
    - `hold_valid`=1: `hold_inst`.
    - Otherwise: `inst_sram_rdata`.
- Branch delay slot: architecturally executed. `pcsource` redirects the fetch after the one currently in decode, so nothing is flushed.
- `pcsource`/targets are ignored while `valid`=0 or `stall`=1.
- Misaligned target:
  - The PC still advances to it and no SRAM read is issued.
  - Decode sees `o_adel`=1 with `o_inst`=0 (SLL $0 = NOP) for exception handling.
  - Next sequential fetch continues from target+4 unless decode redirects.

## Timing
- Fetch latency: address driven in cycle N; instruction on `o_inst` in cycle N+1, with `o_pc` = that address.
- Throughput: one instruction per cycle when `stall`=0.
- After reset release:
  - Cycle 0: `inst_sram_addr` = RESET_PC, `o_valid`=0.
  - Cycle 1: `o_valid`=1, `o_pc`=RESET_PC.
- Stall:
  - `o_pc`/`o_inst` identical on every stalled cycle, from the first stalled cycle to the cycle `stall` drops.
  - SRAM is not re-read during the stall.
  - The cycle `stall` drops, the held instruction is still presented and `npc` comes from that cycle's `pcsource`.
  - The new instruction appears the next cycle.
- Back-to-back stalls separated by one unstalled cycle: the hold buffer is cleared on the unstalled edge and recaptured on the next stalled edge.
- Reset mid-stall or mid-redirect: state returns to reset values asynchronously; the hold buffer is discarded and fetch restarts at RESET_PC.
- `pc_reg`+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 without a flag.

## Test plan
- Reset release:
  - Stimulus: `reset` low 3 cycles, then high; SRAM returns addr-derived data.
  - Required: cycle 0 addr=BFC00000, `o_valid`=0; cycle 1 `o_pc`=BFC00000, `o_valid`=1; cycle 2 `o_pc`=BFC00004.
- Sequential run:
  - Stimulus: `pcsource`=00 for 8 cycles.
  - Required: `o_pc` steps by 4 each cycle; `o_inst` matches the SRAM word for `o_pc`.
- Branch redirect:
  - Stimulus: at `o_pc`=BFC00008 drive `pcsource`=01, `bpc`=BFC00100.
  - Required: next `o_pc`=BFC00100 (delay-slot fetch already present in decode); `jpc`/`jrpc` similarly select 11/10.
- Stall 3 cycles:
  - Stimulus: `stall`=1 at `o_pc`=BFC00010 while SRAM rdata is changed to garbage.
  - Required: `o_pc`/`o_inst` hold the original word for all 3 cycles; `inst_sram_en`=0; after release `o_pc`=BFC00014.
- Misaligned JR:
  - Stimulus: `pcsource`=10, `jrpc`=BFC00102.
  - Required: `inst_sram_en`=0 that cycle; next cycle `o_pc`=BFC00102, `o_adel`=1, `o_inst`=0.
- Reset during stall:
  - Stimulus: assert `reset` low mid-stall with `hold_valid`=1.
  - Required: immediately `o_valid`=0, `o_pc`=BFC00000; after release, the first instruction is the word at BFC00000, not the held word.
